// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI responder with byte-wide TX/RX valid/ready streams and sticky error flags
module spi_slave_core #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss_n,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  input  logic                  clr_flags
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic sclk_prev_q, sclk_prev_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic sclk_s, ss_s, mosi_s, lead, trail, sample, shift, wrap, write, accept, load, complete;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign lead = state_q == ACTIVE && sclk_s != sclk_prev_q && sclk_s != cpol_q;
  assign trail = state_q == ACTIVE && sclk_s != sclk_prev_q && sclk_s == cpol_q;
  assign sample = cpha_q ? trail : lead;
  assign shift = cpha_q ? lead : trail;
  assign wrap = bit_cnt_q == CW'(DATA_WIDTH - 1);
  assign tx_ready = !hold_full_q;
  assign write = tx_valid && tx_ready;
  assign accept = !rx_valid_q || rx_ready;
  assign spi_miso = tx_sh_q[DATA_WIDTH-1];
  assign spi_miso_oe = !ss_s;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy = state_q == ACTIVE;
  assign rx_overrun = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], spi_clk};
    ss_d = {ss_q[SYNC_STAGES-2:0], spi_ss_n};
    mosi_d = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    state_d = state_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    load = 1'b0;
    complete = 1'b0;
    if (state_q == IDLE) begin
      if (!ss_s) begin
        state_d = ACTIVE;
        cpol_d = cpol;
        cpha_d = cpha;
        bit_cnt_d = '0;
        load = !cpha;
      end
    end else if (ss_s) begin
      state_d = IDLE;
      bit_cnt_d = '0;
    end else begin
      if (sample) begin
        rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
        bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
        complete = wrap;
      end
      if (shift) begin
        load = bit_cnt_q == '0;
        tx_sh_d = tx_sh_q << 1;
      end
    end
    if (load) tx_sh_d = hold_full_q ? hold_q : IDLE_BYTE;
    hold_full_d = write || (hold_full_q && !load);
    hold_d = write ? tx_data : hold_q;
    rx_data_d = complete && accept ? rx_sh_d : rx_data_q;
    rx_valid_d = (complete && accept) || (rx_valid_q && !rx_ready);
    rx_overrun_d = (complete && !accept) || (rx_overrun_q && !clr_flags);
    tx_underrun_d = (load && !hold_full_q) || (tx_underrun_q && !clr_flags);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      bit_cnt_q <= '0;
      tx_sh_q <= '1;
      rx_sh_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      ss_q <= ss_d;
      mosi_q <= mosi_d;
      sclk_prev_q <= sclk_prev_d;
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed and randomized SPI master-model bench for spi_slave_core
module tb_spi_slave_core;
  localparam int H = 4;
  logic clk = 1'b0;
  logic reset, cpol, cpha, spi_clk, spi_mosi, spi_ss_n, spi_miso, spi_miso_oe;
  logic [7:0] tx_data, rx_data, mi, m1, m2, exp_mi, tb_byte, mb_byte;
  logic tx_valid, tx_ready, rx_valid, rx_ready, busy, rx_overrun, tx_underrun, clr_flags;
  logic rx_prev;
  bit pre;
  int n_chk = 0;
  int n_fail = 0;
  int rx_rises = 0;
  int r0;
  spi_slave_core dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .clr_flags(clr_flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rx_prev <= rx_valid;
    if (rx_valid && !rx_prev) rx_rises <= rx_rises + 1;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_miso"}, spi_miso, 1);
    chk({p, "_oe"}, spi_miso_oe, 0);
    chk({p, "_tx_ready"}, tx_ready, 1);
    chk({p, "_rx_valid"}, rx_valid, 0);
    chk({p, "_rx_data"}, rx_data, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_overrun"}, rx_overrun, 0);
    chk({p, "_underrun"}, tx_underrun, 0);
  endtask
  task automatic push(input logic [7:0] v);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin
      wait_clk(1);
      t++;
    end
    chk("push_ready", tx_ready, 1);
    tx_data = v;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    chk("tx_ready_drop", tx_ready, 0);
  endtask
  task automatic pop();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    chk("pop_rx_valid", rx_valid, 0);
  endtask
  task automatic clr();
    clr_flags = 1'b1;
    wait_clk(1);
    clr_flags = 1'b0;
  endtask
  task automatic sel(input bit pol, input bit pha);
    cpol = pol;
    cpha = pha;
    spi_clk = pol;
    wait_clk(2 * H);
    spi_ss_n = 1'b0;
    wait_clk(2 * H);
  endtask
  task automatic desel();
    spi_clk = cpol;
    spi_ss_n = 1'b1;
    wait_clk(3 * H);
  endtask
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        spi_mosi = mo[7-i];
        wait_clk(H);
        rd = {rd[6:0], spi_miso};
        spi_clk = ~cpol;
        wait_clk(H);
        if (!(last && i == nbits - 1)) spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        spi_mosi = mo[7-i];
        wait_clk(H);
        rd = {rd[6:0], spi_miso};
        spi_clk = cpol;
        wait_clk(H);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    clr_flags = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    chk_reset("reset");
    push(8'h3C);
    r0 = rx_rises;
    sel(0, 0);
    chk("m0_busy", busy, 1);
    chk("m0_oe", spi_miso_oe, 1);
    chk("m0_loaded", tx_ready, 1);
    xfer(8'hA5, 8, 1, mi);
    desel();
    chk("m0_miso", mi, 8'h3C);
    chk("m0_rx_data", rx_data, 8'hA5);
    chk("m0_rx_valid", rx_valid, 1);
    chk("m0_one_pulse", rx_rises - r0, 1);
    chk("m0_underrun", tx_underrun, 0);
    chk("m0_idle", busy, 0);
    chk("m0_oe_off", spi_miso_oe, 0);
    pop();
    push(8'h81);
    sel(1, 1);
    chk("m3_oe_on", spi_miso_oe, 1);
    xfer(8'h5A, 8, 1, mi);
    chk("m3_oe_held", spi_miso_oe, 1);
    desel();
    chk("m3_oe_off", spi_miso_oe, 0);
    chk("m3_miso", mi, 8'h81);
    chk("m3_rx_data", rx_data, 8'h5A);
    chk("m3_underrun", tx_underrun, 0);
    pop();
    rx_ready = 1'b1;
    push(8'h11);
    sel(0, 0);
    xfer(8'hC7, 8, 0, m1);
    xfer(8'hE2, 8, 1, m2);
    desel();
    rx_ready = 1'b0;
    chk("b2b_first", m1, 8'h11);
    chk("b2b_second", m2, 8'hFF);
    chk("b2b_underrun", tx_underrun, 1);
    chk("b2b_overrun", rx_overrun, 0);
    chk("b2b_rx_data", rx_data, 8'hE2);
    clr();
    chk("b2b_clr", tx_underrun, 0);
    sel(0, 0);
    xfer(8'h01, 8, 0, mi);
    xfer(8'h02, 8, 1, mi);
    desel();
    chk("ovr_rx_data", rx_data, 8'h01);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_flag", rx_overrun, 1);
    pop();
    chk("ovr_kept", rx_data, 8'h01);
    clr();
    chk("ovr_clr", rx_overrun, 0);
    chk("ovr_clr_under", tx_underrun, 0);
    r0 = rx_rises;
    sel(0, 0);
    xfer(8'hF0, 5, 1, mi);
    desel();
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_pulse", rx_rises - r0, 0);
    sel(0, 0);
    xfer(8'h0F, 8, 1, mi);
    desel();
    chk("abort_next_rx", rx_data, 8'h0F);
    chk("abort_next_valid", rx_valid, 1);
    pop();
    clr();
    push(8'hAA);
    sel(0, 0);
    push(8'hBB);
    xfer(8'h3C, 3, 1, mi);
    reset = 1'b1;
    spi_ss_n = 1'b1;
    spi_clk = 1'b0;
    wait_clk(1);
    chk_reset("midrst");
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2 * H);
    chk_reset("postrst");
    push(8'h77);
    sel(0, 0);
    xfer(8'hC3, 8, 1, mi);
    desel();
    chk("postrst_miso", mi, 8'h77);
    chk("postrst_rx", rx_data, 8'hC3);
    chk("postrst_underrun", tx_underrun, 0);
    pop();
    for (int k = 0; k < 8; k++) begin
      pre = 1'($urandom_range(0, 1));
      tb_byte = 8'($urandom);
      mb_byte = 8'($urandom);
      exp_mi = pre ? tb_byte : 8'hFF;
      if (pre) push(tb_byte);
      sel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      xfer(mb_byte, 8, 1, mi);
      desel();
      chk("rnd_miso", mi, exp_mi);
      chk("rnd_rx", rx_data, mb_byte);
      chk("rnd_valid", rx_valid, 1);
      chk("rnd_underrun", tx_underrun, !pre);
      pop();
      clr();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- SPI responder (slave) for the SoC's external SPI bus.
- Pairs with the existing SPI master core; used for board-level loopback and for boards where the SoC is the target of an external host.
- Oversamples spi_clk/spi_ss_n/spi_mosi in the system clock domain.
- Shifts MSB-first bytes in both directions.
- Exposes byte-wide valid/ready TX and RX streams plus sticky error flags.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame.
- SYNC_STAGES, 2, flip-flop synchronizer depth on spi_clk, spi_ss_n, spi_mosi.
- IDLE_BYTE, 8'hFF, byte shifted out when no TX data is buffered.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cpol  input  1  SCK idle level; sampled only while idle.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge. Sampled only while idle.
- spi_clk  input  1  SCK from the external master.
- spi_mosi  input  1  master-out data.
- spi_ss_n  input  1  active-low select.
- spi_miso  output  1  slave-out data (tx_sh MSB).
- spi_miso_oe  output  1  high while synchronized select is asserted.
- tx_data  input  DATA_WIDTH  next byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX holding register empty.
- rx_data  output  DATA_WIDTH  received byte.
- rx_valid  output  1  rx_data valid.
- rx_ready  input  1  consumer accepts rx_data.
- busy  output  1  in ACTIVE state.
- rx_overrun  output  1  sticky: byte dropped because RX holding was full.
- tx_underrun  output  1  sticky: IDLE_BYTE sent because TX holding was empty.
- clr_flags  input  1  clears both sticky flags.

Behaviour:
- Reset (synchronous, active-high, clk only) values:
  - spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0, flags=0.
  - bit_cnt=0, state=IDLE.
  - Reset asserted mid-transfer aborts immediately; the partial byte is lost and the TX holding register is emptied.
- Inputs pass through SYNC_STAGES FFs.
- Edges are detected on synchronized spi_clk from the previous synced value:
  - leading edge = change away from cpol;
  - trailing edge = change back to cpol.
  - Edges are ignored in IDLE.
- Requirement on the master: SCK half-period >= SYNC_STAGES+2 clk. The master core satisfies this with dvsr >= 4.
- FSM:
  - IDLE -> ACTIVE on synced ss_n falling. cpol/cpha are latched and bit_cnt cleared. If cpha=0, tx_sh is loaded (see TX load).
  - ACTIVE -> IDLE on synced ss_n rising. bit_cnt is cleared, a partial RX byte is discarded (no rx_valid), and spi_miso_oe goes 0 the same cycle.
- Sample edge (leading if cpha=0, trailing if cpha=1):
  - rx_sh <= {rx_sh[6:0], mosi}; bit_cnt increments modulo DATA_WIDTH.
  - On wrap to 0 the byte is complete:
    - if RX holding is empty, or rx_ready is high this cycle: rx_data <= new byte, rx_valid=1;
    - else: new byte dropped, rx_overrun=1, old rx_data kept.
- Shift edge (trailing if cpha=0, leading if cpha=1):
  - bit_cnt==0: TX load;
  - otherwise: tx_sh <= tx_sh<<1.
  - With cpha=0, the trailing edge after the 8th sample loads the next byte. That byte is consumed even if ss_n then deasserts.
- TX load:
  - tx_sh <= holding if full, then holding marked empty;
  - else tx_sh <= IDLE_BYTE and tx_underrun=1.
- Latency:
  - First MSB on spi_miso: SYNC_STAGES+1 clk after spi_ss_n falls (cpha=0), or after the first SCK leading edge (cpha=1).
  - rx_valid rises SYNC_STAGES+1 clk after the 8th sample edge.
- Handshakes:
  - TX holding is written when tx_valid&&tx_ready; tx_ready drops the next cycle.
  - A load and a write in the same cycle: the load takes the old content and the write refills, so tx_ready stays 0.
  - rx_valid stays high until rx_valid&&rx_ready.
  - A pop and a completion in the same cycle: the new byte is kept and rx_valid stays 1.
- clr_flags and a flag-set event in the same cycle: set wins.
- busy = state==ACTIVE.
- Changes to cpol/cpha during ACTIVE have no effect until the next select.

Test Plan:
- Mode 0 (cpol=0, cpha=0), dvsr=4: preload tx 8'h3C, master sends 8'hA5.
  -> rx_data=8'hA5 with one rx_valid pulse; master reads 8'h3C; tx_underrun=0.
- Mode 3 (cpol=1, cpha=1): preload 8'h81, master sends 8'h5A.
  -> rx 8'h5A, master reads 8'h81; spi_miso_oe high only while ss_n low.
- Back-to-back 2 bytes in one select, only 8'h11 preloaded.
  -> master reads 8'h11 then 8'hFF; tx_underrun=1; clr_flags clears it.
- rx_ready held 0, master sends 8'h01, 8'h02.
  -> rx_data stays 8'h01, rx_overrun=1; rx_ready=1 pops 8'h01 and rx_valid drops.
- ss_n deasserted after 5 bits of 8'hF0.
  -> no rx_valid, busy=0; the next full byte 8'h0F is received correctly.
- reset pulsed mid-byte with tx holding full.
  -> all outputs at reset values, tx_ready=1; the next transfer works normally.
